// File: rtl/vga_scandoubler_if.sv
// ---------------------------------------------------------------------------
// vga_scandoubler_if
//   Video bundle between the ULA-side source, the scandoubler and the VGA
//   output. The clock and reset are not part of the bundle.
//
//   Input side (15 kHz, ULA pixel rate):
//     pix_ce             one-cycle strobe per input pixel
//     ri, gi, bi         3-bit colour components, valid when pix_ce=1
//     csync_in           composite sync, active low
//     enable_scandoubler 1 = doubled 31 kHz output, 0 = registered bypass
//     scanlines          1 = halve colour on the second replay of a line
//   Output side (31 kHz VGA):
//     ro, go, bo         3-bit colour components
//     hsync_n, vsync_n   separate syncs, active low
//
//   master: the side that supplies ULA video and consumes VGA video
//   slave : the scandoubler itself
// ---------------------------------------------------------------------------
interface vga_scandoubler_if;
  logic       pix_ce;
  logic [2:0] ri;
  logic [2:0] gi;
  logic [2:0] bi;
  logic       csync_in;
  logic       enable_scandoubler;
  logic       scanlines;
  logic [2:0] ro;
  logic [2:0] go;
  logic [2:0] bo;
  logic       hsync_n;
  logic       vsync_n;

  modport master (
    output pix_ce, ri, gi, bi, csync_in, enable_scandoubler, scanlines,
    input  ro, go, bo, hsync_n, vsync_n
  );

  modport slave (
    input  pix_ce, ri, gi, bi, csync_in, enable_scandoubler, scanlines,
    output ro, go, bo, hsync_n, vsync_n
  );
endinterface

// File: rtl/vga_scandoubler.sv
// ---------------------------------------------------------------------------
// vga_scandoubler
//   Line doubler placed after the ULA video output. Each 15 kHz input line is
//   captured into one bank of a two-bank line buffer while the previously
//   completed line is replayed twice from the other bank at the full clk14
//   rate, giving 31 kHz RGB with separate hsync_n / vsync_n. Optional scanline
//   dimming on the second replay, and a registered pass-through bypass.
//
//   Ports:
//     clk14  in  system clock (14 MHz), also the output pixel rate
//     rst_n  in  asynchronous reset, active low
//     vid    vga_scandoubler_if.slave  (pix_ce, ri/gi/bi, csync_in,
//            enable_scandoubler, scanlines in; ro/go/bo, hsync_n, vsync_n out)
//
//   Output pipeline: hcnt_out -> RAM read / sync decode -> output register,
//   so colour and both syncs appear 2 clk14 after the counter value.
// ---------------------------------------------------------------------------
module vga_scandoubler #(
  parameter int unsigned LINE_PIXELS  = 448,
  parameter int unsigned HS_START     = 344,
  parameter int unsigned HS_LEN       = 54,
  parameter int unsigned VS_THRESHOLD = 64
) (
  input  logic             clk14,
  input  logic             rst_n,
  vga_scandoubler_if.slave vid
);

  localparam logic [8:0] PIX_END   = 9'(LINE_PIXELS);
  localparam logic [8:0] PIX_LAST  = 9'(LINE_PIXELS - 1);
  localparam logic [8:0] HCNT_MAX  = 9'd511;
  localparam logic [8:0] HS_FIRST  = 9'(HS_START);
  localparam logic [8:0] HS_STOP   = 9'(HS_START + HS_LEN);
  localparam logic [6:0] VS_LIMIT  = 7'(VS_THRESHOLD);
  localparam logic [6:0] VS_ARM    = 7'(VS_THRESHOLD - 1);

  // Input-side state
  logic       csync_q_reg,   csync_q_next;
  logic [8:0] hcnt_in_reg,   hcnt_in_next;
  logic       wbank_reg,     wbank_next;
  logic [6:0] low_cnt_reg,   low_cnt_next;
  logic       vs_flag_reg,   vs_flag_next;

  // Output-side state. line_seen_reg blanks the colour until a complete line
  // has been captured since reset, so no stale buffer contents are shown.
  logic [8:0] hcnt_out_reg,  hcnt_out_next;
  logic       second_reg,    second_next;
  logic       line_seen_reg, line_seen_next;

  // First pipeline stage (runs alongside the RAM read)
  logic       hs_act1_reg;
  logic       dim1_reg;
  logic       vs1_reg;
  logic       valid1_reg;

  // Output registers
  logic [2:0] ro_reg, ro_next;
  logic [2:0] go_reg, go_next;
  logic [2:0] bo_reg, bo_next;
  logic       hsync_n_reg, hsync_n_next;
  logic       vsync_n_reg, vsync_n_next;

  logic       line_start;
  logic       wr_en;
  logic       hs_window;
  logic [8:0] rd_data;
  logic [8:0] shown_rgb;
  logic [8:0] dimmed_rgb;

  // Line buffer: bank select is the address MSB, 9-bit {r,g,b} words.
  logic [8:0] line_mem [0:1023];

  assign line_start = vid.pix_ce & csync_q_reg & ~vid.csync_in;
  assign hs_window  = (hcnt_out_reg >= HS_FIRST) && (hcnt_out_reg < HS_STOP);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    csync_q_next   = csync_q_reg;
    hcnt_in_next   = hcnt_in_reg;
    wbank_next     = wbank_reg;
    low_cnt_next   = low_cnt_reg;
    vs_flag_next   = vs_flag_reg;
    wr_en          = 1'b0;

    if (vid.pix_ce) begin
      csync_q_next = vid.csync_in;

      if (line_start) begin
        hcnt_in_next = '0;
        wbank_next   = ~wbank_reg;
      end else begin
        // Overlong lines: drop writes past the line end instead of wrapping
        // onto the start of the line being captured.
        wr_en = (hcnt_in_reg < PIX_END);
        if (hcnt_in_reg != HCNT_MAX) begin
          hcnt_in_next = hcnt_in_reg + 9'd1;
        end
      end

      if (vid.csync_in) begin
        low_cnt_next = '0;
        vs_flag_next = 1'b0;
      end else if (low_cnt_reg != VS_LIMIT) begin
        low_cnt_next = low_cnt_reg + 7'd1;
        // Flag on the very sample that brings the count to the threshold.
        if (low_cnt_reg == VS_ARM) begin
          vs_flag_next = 1'b1;
        end
      end
    end

    // Output counter: a new input line always restarts the replay, taking
    // priority over the normal end-of-line wrap.
    hcnt_out_next  = hcnt_out_reg + 9'd1;
    second_next    = second_reg;
    line_seen_next = line_seen_reg;
    if (line_start) begin
      hcnt_out_next  = '0;
      second_next    = 1'b0;
      line_seen_next = 1'b1;
    end else if (hcnt_out_reg == PIX_LAST) begin
      hcnt_out_next = '0;
      second_next   = ~second_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Line buffer, synchronous write and registered read. The read side always
  // uses the bank that is not being written.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk14) begin
    if (wr_en) begin
      line_mem[{wbank_reg, hcnt_in_reg}] <= {vid.ri, vid.gi, vid.bi};
    end
    rd_data <= line_mem[{~wbank_reg, hcnt_out_reg}];
  end

  // -------------------------------------------------------------------------
  // Output formatting
  // -------------------------------------------------------------------------
  assign shown_rgb = (valid1_reg && !hs_act1_reg) ? rd_data : 9'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dim
      assign dimmed_rgb[gi*3 +: 3] = dim1_reg ? {1'b0, shown_rgb[gi*3+1 +: 2]}
                                              : shown_rgb[gi*3 +: 3];
    end
  endgenerate

  always_comb begin
    ro_next      = dimmed_rgb[8:6];
    go_next      = dimmed_rgb[5:3];
    bo_next      = dimmed_rgb[2:0];
    hsync_n_next = ~hs_act1_reg;
    vsync_n_next = vs1_reg;
    if (!vid.enable_scandoubler) begin
      ro_next      = vid.ri;
      go_next      = vid.gi;
      bo_next      = vid.bi;
      hsync_n_next = vid.csync_in;
      vsync_n_next = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      csync_q_reg   <= 1'b1;
      hcnt_in_reg   <= '0;
      wbank_reg     <= 1'b0;
      low_cnt_reg   <= '0;
      vs_flag_reg   <= 1'b0;
      hcnt_out_reg  <= '0;
      second_reg    <= 1'b0;
      line_seen_reg <= 1'b0;
      hs_act1_reg   <= 1'b0;
      dim1_reg      <= 1'b0;
      vs1_reg       <= 1'b1;
      valid1_reg    <= 1'b0;
      ro_reg        <= '0;
      go_reg        <= '0;
      bo_reg        <= '0;
      hsync_n_reg   <= 1'b1;
      vsync_n_reg   <= 1'b1;
    end else begin
      csync_q_reg   <= csync_q_next;
      hcnt_in_reg   <= hcnt_in_next;
      wbank_reg     <= wbank_next;
      low_cnt_reg   <= low_cnt_next;
      vs_flag_reg   <= vs_flag_next;
      hcnt_out_reg  <= hcnt_out_next;
      second_reg    <= second_next;
      line_seen_reg <= line_seen_next;
      hs_act1_reg   <= hs_window;
      dim1_reg      <= vid.scanlines & second_reg;
      vs1_reg       <= ~vs_flag_reg;
      valid1_reg    <= line_seen_reg;
      ro_reg        <= ro_next;
      go_reg        <= go_next;
      bo_reg        <= bo_next;
      hsync_n_reg   <= hsync_n_next;
      vsync_n_reg   <= vsync_n_next;
    end
  end

  assign vid.ro      = ro_reg;
  assign vid.go      = go_reg;
  assign vid.bo      = bo_reg;
  assign vid.hsync_n = hsync_n_reg;
  assign vid.vsync_n = vsync_n_reg;

endmodule

// File: tb/tb_vga_scandoubler.sv
// ---------------------------------------------------------------------------
// tb_vga_scandoubler
//   Directed bench for vga_scandoubler. Outputs are logged every clk14 (on the
//   falling edge) as {ro,go,bo,hsync_n,vsync_n}; line starts record their
//   cycle index so expected replay positions are computed from it:
//   output for hcnt_out=k appears at log[start + 2 + k].
// ---------------------------------------------------------------------------
module tb_vga_scandoubler;
  localparam int LOGN = 16384;

  logic clk14 = 1'b0;
  logic rst_n;

  vga_scandoubler_if vif ();

  vga_scandoubler dut (
    .clk14 (clk14),
    .rst_n (rst_n),
    .vid   (vif.slave)
  );

  always #5 clk14 = ~clk14;

  int cyc      = 0;
  int pix_cyc  = 0;
  int checks   = 0;
  int failures = 0;
  logic [10:0] out_log [LOGN];

  always @(posedge clk14) cyc <= cyc + 1;

  always @(negedge clk14) begin
    if (cyc < LOGN) out_log[cyc] <= {vif.ro, vif.go, vif.bo, vif.hsync_n, vif.vsync_n};
  end

  function automatic logic [10:0] w(input logic [2:0] r, input logic [2:0] g,
                                    input logic [2:0] b, input logic hs, input logic vs);
    return {r, g, b, hs, vs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One input pixel: strobe cycle followed by one idle cycle.
  task automatic pix(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                     input logic cs);
    vif.ri = r; vif.gi = g; vif.bi = b; vif.csync_in = cs; vif.pix_ce = 1'b1;
    @(posedge clk14); @(negedge clk14);
    pix_cyc = cyc;
    vif.pix_ce = 1'b0;
    @(posedge clk14); @(negedge clk14);
  endtask

  task automatic idle(input int n);
    vif.pix_ce = 1'b0;
    repeat (n) begin @(posedge clk14); @(negedge clk14); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, c0, c1, c3, c4, c5, s, v, h, zeros;
    logic [8:0] i9;
    logic [8:0] kk;
    logic [10:0] e;

    vif.pix_ce = 1'b0; vif.ri = '0; vif.gi = '0; vif.bi = '0;
    vif.csync_in = 1'b1; vif.enable_scandoubler = 1'b1; vif.scanlines = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // 1: reset held with pix_ce toggling
    @(negedge clk14);
    r0 = cyc;
    for (int i = 0; i < 6; i++) pix(3'd7, 3'd7, 3'd7, i[0]);
    for (int i = r0; i < cyc; i++) chk($sformatf("reset[%0d]", i), 32'(out_log[i]), 32'(w(0, 0, 0, 1, 1)));
    vif.csync_in = 1'b1;
    rst_n = 1'b1;
    pix(0, 0, 0, 1); pix(0, 0, 0, 1);

    // 2/3: ramp line, replayed twice with hsync window
    pix(0, 0, 0, 0);
    for (int i = 0; i < 448; i++) begin
      i9 = 9'(i);
      pix(i9[2:0], i9[5:3], i9[8:6], 1'b1);
    end
    pix(0, 0, 0, 0);
    c0 = pix_cyc;
    for (int i = 0; i < 448; i++) pix(3'd7, 3'd7, 3'd7, 1'b1);
    vif.scanlines = 1'b1;
    pix(0, 0, 0, 0);
    c1 = pix_cyc;
    for (int k = 0; k < 896; k++) begin
      kk = 9'(k % 448);
      if (kk >= 9'd344 && kk < 9'd398) e = w(0, 0, 0, 0, 1);
      else                             e = w(kk[2:0], kk[5:3], kk[8:6], 1, 1);
      chk($sformatf("ramp[%0d]", k), 32'(out_log[c0 + 2 + k]), 32'(e));
    end

    // 4: all-7 line with scanlines=1 then scanlines=0
    for (int i = 0; i < 448; i++) pix(3'd7, 3'd7, 3'd7, 1'b1);
    vif.scanlines = 1'b0;
    pix(0, 0, 0, 0);
    c3 = pix_cyc;
    chk("scan1_first_k0",    32'(out_log[c1 + 2]),         32'(w(7, 7, 7, 1, 1)));
    chk("scan1_first_k447",  32'(out_log[c1 + 2 + 447]),   32'(w(7, 7, 7, 1, 1)));
    chk("scan1_second_k0",   32'(out_log[c1 + 450]),       32'(w(3, 3, 3, 1, 1)));
    chk("scan1_second_k200", 32'(out_log[c1 + 450 + 200]), 32'(w(3, 3, 3, 1, 1)));
    chk("scan1_second_hs",   32'(out_log[c1 + 450 + 350]), 32'(w(0, 0, 0, 0, 1)));
    chk("scan1_second_k447", 32'(out_log[c1 + 450 + 447]), 32'(w(3, 3, 3, 1, 1)));

    // 6a: short line of 300 pixels
    for (int i = 0; i < 300; i++) pix(3'd5, 3'd2, 3'd1, 1'b1);
    chk("scan0_first_k0",    32'(out_log[c3 + 2]),         32'(w(7, 7, 7, 1, 1)));
    chk("scan0_second_k100", 32'(out_log[c3 + 450 + 100]), 32'(w(7, 7, 7, 1, 1)));
    vif.scanlines = 1'b1;
    pix(0, 0, 0, 0);
    c4 = pix_cyc;

    // 6b: 650 pixels without sync; first 448 must survive
    for (int i = 0; i < 650; i++) begin
      if (i < 448) pix(3'd1, 3'd6, 3'd3, 1'b1);
      else         pix(3'd6, 3'd1, 3'd4, 1'b1);
    end
    chk("short_restart_k0",   32'(out_log[c4 + 2]),       32'(w(5, 2, 1, 1, 1)));
    chk("short_first_k299",   32'(out_log[c4 + 2 + 299]), 32'(w(5, 2, 1, 1, 1)));
    chk("short_second_k0",    32'(out_log[c4 + 450]),     32'(w(2, 1, 0, 1, 1)));
    chk("short_second_k299",  32'(out_log[c4 + 450 + 299]), 32'(w(2, 1, 0, 1, 1)));
    chk("repeat_third_k0",    32'(out_log[c4 + 898]),     32'(w(5, 2, 1, 1, 1)));
    vif.scanlines = 1'b0;
    pix(0, 0, 0, 0);
    c5 = pix_cyc;
    for (int i = 0; i < 448; i++) pix(3'd0, 3'd0, 3'd0, 1'b1);
    idle(2);
    chk("long_first_k0",    32'(out_log[c5 + 2]),         32'(w(1, 6, 3, 1, 1)));
    chk("long_first_k1",    32'(out_log[c5 + 3]),         32'(w(1, 6, 3, 1, 1)));
    chk("long_first_k201",  32'(out_log[c5 + 2 + 201]),   32'(w(1, 6, 3, 1, 1)));
    chk("long_first_k447",  32'(out_log[c5 + 2 + 447]),   32'(w(1, 6, 3, 1, 1)));
    chk("long_second_k0",   32'(out_log[c5 + 450]),       32'(w(1, 6, 3, 1, 1)));
    chk("long_second_k447", 32'(out_log[c5 + 450 + 447]), 32'(w(1, 6, 3, 1, 1)));

    // 5: vsync threshold
    s = cyc;
    for (int i = 0; i < 63; i++) pix(0, 0, 0, 0);
    pix(0, 0, 0, 1); pix(0, 0, 0, 1); pix(0, 0, 0, 1);
    idle(2);
    zeros = 0;
    for (int i = s; i < cyc; i++) if (out_log[i][0] == 1'b0) zeros++;
    chk("vs_63_low_count", 32'(zeros), 32'd0);
    v = 0;
    for (int i = 0; i < 66; i++) begin
      pix(0, 0, 0, 0);
      if (i == 63) v = pix_cyc;
    end
    pix(0, 0, 0, 1);
    h = pix_cyc;
    idle(3);
    chk("vs_before_assert", 32'(out_log[v + 1][0]), 32'd1);
    chk("vs_assert",        32'(out_log[v + 2][0]), 32'd0);
    chk("vs_held",          32'(out_log[h + 1][0]), 32'd0);
    chk("vs_release",       32'(out_log[h + 2][0]), 32'd1);

    // Bypass
    vif.enable_scandoubler = 1'b0;
    pix(3'd5, 3'd3, 3'd6, 1'b0);
    chk("bypass_a", 32'(out_log[pix_cyc]), 32'(w(5, 3, 6, 0, 1)));
    pix(3'd2, 3'd4, 3'd1, 1'b1);
    chk("bypass_b", 32'(out_log[pix_cyc]), 32'(w(2, 4, 1, 1, 1)));
    for (int i = 0; i < 70; i++) pix(3'd3, 3'd5, 3'd7, 1'b0);
    chk("bypass_vsync_forced", 32'(out_log[pix_cyc]), 32'(w(3, 5, 7, 0, 1)));
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
